// File: rtl/running_window_buffer.sv
// Sliding-window sample buffer: pairs every accepted sample with the sample leaving
// the N-deep window, giving the running-sum adder its x and m operands.
module running_window_buffer #(
   parameter int DATA_W   = 32,
   parameter int WIN_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_new,
   output logic [DATA_W-1:0]   out_old,
   output logic                out_full,
   output logic [WIN_LOG2:0]   fill_count
);

   localparam int                  DEPTH    = 1 << WIN_LOG2;
   localparam logic [WIN_LOG2:0]   CNT_FULL = {1'b1, {WIN_LOG2{1'b0}}};
   localparam logic [WIN_LOG2:0]   CNT_ONE  = (WIN_LOG2 + 1)'(1);
   localparam logic [WIN_LOG2-1:0] PTR_ONE  = WIN_LOG2'(1);

   localparam logic ST_FILL = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic                state;
   logic [WIN_LOG2-1:0] wptr;
   logic [WIN_LOG2:0]   cnt;
   logic [WIN_LOG2:0]   cnt_next;
   logic                accept;
   logic [DATA_W-1:0]   evict;

   logic [DATA_W-1:0]   win_buf [DEPTH];

   logic                vld_p1;
   logic [DATA_W-1:0]   new_p1;
   logic [DATA_W-1:0]   old_p1;
   logic                full_p1;

   // Single output register: a new sample is taken only when the slot is empty or draining.
   assign in_ready = !clear && (!vld_p1 || out_ready);
   assign accept   = in_valid && in_ready;
   assign cnt_next = (state == ST_FILL) ? cnt + CNT_ONE : cnt;

   // Unwritten entries are never read: the evicted operand is zero until the window is full.
   assign evict    = (state == ST_RUN) ? win_buf[wptr] : '0;

   // Window storage: not reset, read-before-write on the same entry.
   always_ff @(posedge clk) begin
      if (accept) begin
         win_buf[wptr] <= in_data;
      end
   end

   // ---- stage p1: output register, pointer and fill state ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_FILL;
         wptr    <= '0;
         cnt     <= '0;
         vld_p1  <= 1'b0;
         new_p1  <= '0;
         old_p1  <= '0;
         full_p1 <= 1'b0;
      end else if (clear) begin
         state   <= ST_FILL;
         wptr    <= '0;
         cnt     <= '0;
         vld_p1  <= 1'b0;
         full_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         new_p1  <= in_data;
         old_p1  <= evict;
         full_p1 <= (cnt_next == CNT_FULL);
         cnt     <= cnt_next;
         wptr    <= wptr + PTR_ONE;
         if (cnt_next == CNT_FULL) begin
            state <= ST_RUN;
         end
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign out_valid  = vld_p1;
   assign out_new    = new_p1;
   assign out_old    = old_p1;
   assign out_full   = full_p1;
   assign fill_count = cnt;

endmodule

// File: tb/tb_running_window_buffer.sv
// Scoreboard bench for running_window_buffer: an N=4 instance driven with directed
// and random traffic, and an N=2 instance with alternating-valid random traffic.
module tb_running_window_buffer;

   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          a_clear = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
   logic [DW-1:0] a_in_data = '0;
   logic          a_in_ready, a_out_valid, a_out_full;
   logic [DW-1:0] a_out_new, a_out_old;
   logic [2:0]    a_fill;

   logic          b_clear = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
   logic [DW-1:0] b_in_data = '0;
   logic          b_in_ready, b_out_valid, b_out_full;
   logic [DW-1:0] b_out_new, b_out_old;
   logic [1:0]    b_fill;

   running_window_buffer #(.DATA_W(DW), .WIN_LOG2(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(a_clear),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_new(a_out_new), .out_old(a_out_old), .out_full(a_out_full),
      .fill_count(a_fill)
   );

   running_window_buffer #(.DATA_W(DW), .WIN_LOG2(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(b_clear),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_new(b_out_new), .out_old(b_out_old), .out_full(b_out_full),
      .fill_count(b_fill)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   typedef struct {
      logic [DW-1:0] nw;
      logic [DW-1:0] od;
      logic          full;
      int            fill;
   } beat_t;

   beat_t         a_sb[$], b_sb[$];
   logic [DW-1:0] a_hist[$], b_hist[$];
   beat_t         a_me, a_ce, b_me, b_ce;

   // Reference: the window is the last N accepted samples since reset/clear.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || a_clear) begin
         a_hist.delete();
         a_sb.delete();
      end else if (a_in_valid && a_in_ready) begin
         a_me.nw = a_in_data;
         a_me.od = (a_hist.size() == 4) ? a_hist[0] : '0;
         a_hist.push_back(a_in_data);
         if (a_hist.size() > 4) void'(a_hist.pop_front());
         a_me.fill = a_hist.size();
         a_me.full = (a_hist.size() == 4);
         a_sb.push_back(a_me);
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || b_clear) begin
         b_hist.delete();
         b_sb.delete();
      end else if (b_in_valid && b_in_ready) begin
         b_me.nw = b_in_data;
         b_me.od = (b_hist.size() == 2) ? b_hist[0] : '0;
         b_hist.push_back(b_in_data);
         if (b_hist.size() > 2) void'(b_hist.pop_front());
         b_me.fill = b_hist.size();
         b_me.full = (b_hist.size() == 2);
         b_sb.push_back(b_me);
      end
   end

   // Monitors: a beat is consumed when valid and ready meet at the coming edge.
   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready) begin
         if (a_sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_beat: got unexpected beat new=%0d, required none", a_out_new);
         end else begin
            a_ce = a_sb.pop_front();
            check("a_new", a_out_new, a_ce.nw);
            check("a_old", a_out_old, a_ce.od);
            check("a_full", a_out_full, a_ce.full);
            check("a_fill", a_fill, a_ce.fill);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_out_valid && b_out_ready) begin
         if (b_sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_beat: got unexpected beat new=%0d, required none", b_out_new);
         end else begin
            b_ce = b_sb.pop_front();
            check("b_new", b_out_new, b_ce.nw);
            check("b_old", b_out_old, b_ce.od);
            check("b_full", b_out_full, b_ce.full);
            check("b_fill", b_fill, b_ce.fill);
         end
      end
   end

   task automatic send_a(input int d);
      int t;
      t = 0;
      a_in_valid = 1'b1;
      a_in_data  = DW'(d);
      @(negedge clk);
      while (!a_in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!a_in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL a_send_timeout: in_ready got 0, required 1");
      end
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
   endtask

   task automatic clear_a();
      a_clear = 1'b1;
      @(posedge clk);
      #1;
      a_clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      @(negedge clk);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_new", a_out_new, 0);
      check("rst_out_old", a_out_old, 0);
      check("rst_out_full", a_out_full, 0);
      check("rst_fill", a_fill, 0);
      check("rst_in_ready", a_in_ready, 1);
      check("rst_b_valid", b_out_valid, 0);
      check("rst_b_fill", b_fill, 0);
      @(posedge clk);
      #1;

      // Fill then run: beats (1,0)..(4,0),(5,1),(6,2).
      for (int i = 1; i <= 6; i++) send_a(i);
      @(negedge clk);
      check("seq6_new", a_out_new, 6);
      check("seq6_old", a_out_old, 2);
      check("seq6_fill", a_fill, 4);
      check("seq6_full", a_out_full, 1);

      // Clear with a sample offered on the same cycle: it must be refused.
      @(posedge clk);
      #1;
      a_clear    = 1'b1;
      a_in_valid = 1'b1;
      a_in_data  = 16'd99;
      @(negedge clk);
      check("clr_in_ready", a_in_ready, 0);
      @(posedge clk);
      #1;
      check("clr_out_valid", a_out_valid, 0);
      check("clr_fill", a_fill, 0);
      a_clear    = 1'b0;
      a_in_valid = 1'b0;
      send_a(7);
      send_a(8);
      @(negedge clk);
      check("post_clr_new", a_out_new, 8);
      check("post_clr_old", a_out_old, 0);
      check("post_clr_fill", a_fill, 2);

      // Pointer wrap: 12 samples through a 4-deep window.
      @(posedge clk);
      #1;
      clear_a();
      for (int i = 10; i <= 21; i++) send_a(i);
      @(negedge clk);
      check("wrap_old", a_out_old, 17);

      // Backpressure: the first beat holds while out_ready is low.
      @(posedge clk);
      #1;
      clear_a();
      send_a(1);
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 16'd2;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", a_in_ready, 0);
         check("bp_out_valid", a_out_valid, 1);
         check("bp_hold_new", a_out_new, 1);
         check("bp_hold_old", a_out_old, 0);
      end
      @(posedge clk);
      #1;
      a_out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) send_a(i);
      @(negedge clk);
      check("bp_new", a_out_new, 5);
      check("bp_old", a_out_old, 1);

      // Asynchronous reset in the middle of a clock phase while in RUN.
      @(posedge clk);
      #1;
      clear_a();
      for (int i = 1; i <= 5; i++) send_a(i);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", a_out_valid, 0);
      check("arst_out_new", a_out_new, 0);
      check("arst_out_old", a_out_old, 0);
      check("arst_fill", a_fill, 0);
      check("arst_full", a_out_full, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_a(9);
      @(negedge clk);
      check("arst_after_new", a_out_new, 9);
      check("arst_after_old", a_out_old, 0);
      check("arst_after_fill", a_fill, 1);

      // Random traffic with backpressure and occasional clears.
      @(posedge clk);
      #1;
      for (int i = 0; i < 300; i++) begin
         a_in_valid  = 1'($urandom_range(0, 1));
         a_in_data   = DW'($urandom);
         a_out_ready = ($urandom_range(0, 3) != 0);
         a_clear     = ($urandom_range(0, 31) == 0);
         @(posedge clk);
         #1;
      end
      a_in_valid  = 1'b0;
      a_clear     = 1'b0;
      a_out_ready = 1'b1;

      // N=2 window: alternating valid, random downstream readiness.
      for (int i = 0; i < 200; i++) begin
         b_in_valid  = ~b_in_valid;
         b_in_data   = DW'($urandom);
         b_out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("a_sb_drained", a_sb.size(), 0);
      check("b_sb_drained", b_sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/running_window_buffer.md
# running_window_buffer

Sliding-window sample buffer that sits directly upstream of the running-sum adder in the running-mean IP. Each accepted sample is emitted together with the sample leaving the window, giving the adder its new-sample (`x`) and evicted-sample (`m`) operands for `sum_next = sum + (x - m)`. During the initial fill the evicted operand is forced to zero, so the downstream sum accumulates cleanly from reset or clear.

## Interface

Parameters:
- `DATA_W`, 32, sample width; matches adder operand width.
- `WIN_LOG2`, 4, log2 of window length; N = 2^WIN_LOG2, legal range 1..8.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush of window state (one-cycle pulse or level).
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  DATA_W  incoming sample.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_new`  out  DATA_W  sample just entering window (adder `x`).
- `out_old`  out  DATA_W  sample leaving window, 0 while filling (adder `m`).
- `out_full`  out  1  window holds N samples after this beat.
- `fill_count`  out  WIN_LOG2+1  samples currently in window, saturates at N.

## Operation

- Storage: N-entry register array `buf[0..N-1]`, write pointer `wptr` (WIN_LOG2 bits, wraps N-1 -> 0 naturally).
- States: FILL (fill_count < N), RUN (fill_count == N).
- Accept = `in_valid && in_ready`. On accept:
  - `out_new <= in_data`.
  - FILL: `out_old <= 0`; fill_count += 1; state moves to RUN when fill_count reaches N.
  - RUN: `out_old <= buf[wptr]` (value written N accepts earlier); fill_count unchanged.
  - `buf[wptr] <= in_data`; `wptr <= wptr + 1`.
  - `out_full <= (fill_count_next == N)`.
- The read of `buf[wptr]` and the write to the same entry occur in the same cycle; the read returns the old contents.
- Array contents are not reset. Correctness relies on FILL forcing `out_old` to 0, never reading unwritten entries.
- `clear`, highest priority after reset:
  - state -> FILL, `wptr <= 0`, fill_count <= 0, `out_valid <= 0`, `out_full <= 0`.
  - `in_ready` is low while `clear` is high, so no sample is accepted and none is lost silently.
- No arithmetic is performed; `out_new`/`out_old` pass through bit-exact, unsigned/signed-agnostic.

## Timing

- Reset values: `out_valid` 0, `out_new` 0, `out_old` 0, `out_full` 0, `fill_count` 0, `wptr` 0, state FILL. `in_ready` follows its combinational equation (1 after reset).
- `in_ready = !clear && (!out_valid || out_ready)`. Single output register; the block does not buffer a second beat.
- Latency: sample accepted in cycle t appears on `out_*` with `out_valid` high in cycle t+1.
- Throughput: one sample per cycle while `out_ready` is held high.
- Output hold: while `out_valid && !out_ready`, all `out_*` are stable and no accept occurs.
- `out_valid` falls after a beat is taken (`out_valid && out_ready`) with no accept in the same cycle. It stays high with new data if an accept coincides with the take.
- `fill_count` updates in the same edge as the output register. It reflects the count including the beat currently presented.
- Reset asserted mid-stream: all state clears immediately (async). The first beat after release has `out_old = 0`.

## Test plan

- N=4 (`WIN_LOG2=2`), `out_ready=1`, feed 1..6 back-to-back -> beats (new,old) = (1,0),(2,0),(3,0),(4,0),(5,1),(6,2). `out_full` high from beat 4. `fill_count` = 1,2,3,4,4,4.
- N=4, feed 10..21 (12 samples) -> beat k≥5 has `out_old = out_new − 4`. This exercises `wptr` wrap three times.
- Backpressure: N=4, hold `out_ready=0` for 3 cycles after the first beat -> `in_ready=0`, beat (1,0) stable, no sample consumed. On release, the stream continues without loss or duplication.
- `clear` after 6 samples, with `in_valid=1` on the clear cycle -> that sample is not accepted and `out_valid=0` next cycle. Feeding 7,8 then gives (7,0),(8,0) and `fill_count` 1,2.
- Async reset pulse mid-RUN (N=4, after 5 samples) -> outputs go to 0 immediately. Feeding 9 after release gives (9,0) and `fill_count=1`.
- N=2, alternate `in_valid` 1/0 with random `out_ready` -> the output sequence matches a reference N=2 delay-line model beat-for-beat.
